// File: rtl/upc_checkout_ctrl_if.sv
// Checkout controller bus: the item handshake, the operator controls and
// the tally/status outputs. The master (input debouncing and test drivers)
// presents items. The slave (the controller) classifies and counts them.
interface upc_checkout_ctrl_if #(
    parameter int COUNT_W  = 8,
    parameter int STOLEN_W = 4
) ();
    // Item handshake
    logic                item_valid;
    logic [2:0]          item_upc;
    logic                item_marked;
    logic                item_ready;

    // Operator / transaction controls
    logic                end_txn;
    logic                alarm_ack;

    // Status and tallies
    logic                alarm;
    logic                last_discount;
    logic                last_stolen;
    logic [COUNT_W-1:0]  item_count;
    logic [COUNT_W-1:0]  discount_count;
    logic [STOLEN_W-1:0] stolen_count;
    logic                txn_done;
    logic                busy;

    modport master (
        output item_valid, item_upc, item_marked, end_txn, alarm_ack,
        input  item_ready, alarm, last_discount, last_stolen,
               item_count, discount_count, stolen_count, txn_done, busy
    );

    modport slave (
        input  item_valid, item_upc, item_marked, end_txn, alarm_ack,
        output item_ready, alarm, last_discount, last_stolen,
               item_count, discount_count, stolen_count, txn_done, busy
    );
endinterface

// File: rtl/upc_checkout_ctrl.sv
// Sequential UPC checkout controller. It classifies each accepted item as
// discounted and/or stolen and tallies items per transaction. A stolen item
// halts scanning in ALARM until the operator acknowledges it.
module upc_checkout_ctrl #(
    parameter int COUNT_W  = 8,
    parameter int STOLEN_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    upc_checkout_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ALARM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0]  COUNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [STOLEN_W-1:0] STOLEN_MAX = {STOLEN_W{1'b1}};

    state_t              state_q, state_d;
    logic [COUNT_W-1:0]  item_count_q, item_count_d;
    logic [COUNT_W-1:0]  discount_count_q, discount_count_d;
    logic [STOLEN_W-1:0] stolen_count_q, stolen_count_d;
    logic                last_discount_q, last_discount_d;
    logic                last_stolen_q, last_stolen_d;

    logic u_bit, p_bit, c_bit;
    logic is_discount, is_expensive, is_stolen;
    logic item_ready;
    logic accept;

    // Classify the presented item with the UPC discount/stolen rules
    always_comb begin
        u_bit        = bus.item_upc[2];
        p_bit        = bus.item_upc[1];
        c_bit        = bus.item_upc[0];
        is_discount  = (~u_bit & ~p_bit) | (u_bit & p_bit & ~c_bit);
        is_expensive = (u_bit & c_bit) | (~u_bit & ~p_bit & ~c_bit);
        is_stolen    = is_expensive & ~bus.item_marked;
    end

    // The handshake and status outputs are decoded from the state register
    // only, so the inputs have no combinational path to them.
    assign item_ready = (state_q == IDLE) || (state_q == SCAN);
    assign accept     = bus.item_valid & item_ready;

    assign bus.item_ready     = item_ready;
    assign bus.alarm          = (state_q == ALARM);
    assign bus.txn_done       = (state_q == DONE);
    assign bus.busy           = (state_q == SCAN) || (state_q == ALARM);
    assign bus.last_discount  = last_discount_q;
    assign bus.last_stolen    = last_stolen_q;
    assign bus.item_count     = item_count_q;
    assign bus.discount_count = discount_count_q;
    assign bus.stolen_count   = stolen_count_q;

    // Next-state and counter update. In IDLE an accepted item starts a fresh tally.
    always_comb begin
        // NOTE: every signal gets a default before the case, so paths
        // that do not assign it hold the value and no latch is inferred.
        state_d          = state_q;
        item_count_d     = item_count_q;
        discount_count_d = discount_count_q;
        stolen_count_d   = stolen_count_q;
        last_discount_d  = last_discount_q;
        last_stolen_d    = last_stolen_q;

        unique case (state_q)
            IDLE: begin
                // end_txn is deliberately ignored: no transaction is open yet
                if (accept) begin
                    item_count_d     = COUNT_W'(1);
                    discount_count_d = COUNT_W'(is_discount);
                    stolen_count_d   = STOLEN_W'(is_stolen);
                    last_discount_d  = is_discount;
                    last_stolen_d    = is_stolen;
                    state_d          = is_stolen ? ALARM : SCAN;
                end
            end

            SCAN: begin
                if (accept) begin
                    if (item_count_q != COUNT_MAX)
                        item_count_d = item_count_q + COUNT_W'(1);
                    if (is_discount && (discount_count_q != COUNT_MAX))
                        discount_count_d = discount_count_q + COUNT_W'(1);
                    if (is_stolen && (stolen_count_q != STOLEN_MAX))
                        stolen_count_d = stolen_count_q + STOLEN_W'(1);
                    last_discount_d = is_discount;
                    last_stolen_d   = is_stolen;
                end
                // A stolen item counts first. It takes priority over a
                // simultaneous end_txn, which is then dropped.
                if (accept && is_stolen)
                    state_d = ALARM;
                else if (bus.end_txn)
                    state_d = DONE;
            end

            ALARM: begin
                if (bus.alarm_ack)
                    state_d = SCAN;
            end

            DONE: begin
                // Counters hold through DONE and IDLE so the display keeps the totals
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and tally registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples the pre-edge values no matter how the statements are ordered.
        if (!reset_n) begin
            // NOTE: the reset is sampled on the clock edge (synchronous).
            // It clears every register, including a mid-ALARM state.
            state_q          <= IDLE;
            item_count_q     <= '0;
            discount_count_q <= '0;
            stolen_count_q   <= '0;
            last_discount_q  <= 1'b0;
            last_stolen_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            item_count_q     <= item_count_d;
            discount_count_q <= discount_count_d;
            stolen_count_q   <= stolen_count_d;
            last_discount_q  <= last_discount_d;
            last_stolen_q    <= last_stolen_d;
        end
    end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Scoreboard bench for upc_checkout_ctrl. The stimulus tasks step a
// transaction-level reference model and queue the expected outputs for each
// cycle. A monitor pops the queue on every falling edge and compares.
module tb_upc_checkout_ctrl;

    localparam int COUNT_W    = 8;
    localparam int STOLEN_W   = 4;
    localparam int COUNT_MAX  = (1 << COUNT_W) - 1;
    localparam int STOLEN_MAX = (1 << STOLEN_W) - 1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    upc_checkout_ctrl_if #(.COUNT_W(COUNT_W), .STOLEN_W(STOLEN_W)) bus ();

    upc_checkout_ctrl #(.COUNT_W(COUNT_W), .STOLEN_W(STOLEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit ready;
        bit alarm;
        bit done;
        bit busy;
        bit last_d;
        bit last_s;
        int items;
        int disc;
        int stol;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int alarm_rises = 0;

    // Reference model state: the open transaction and its tallies
    bit m_in_txn, m_alarm, m_closing, m_last_d, m_last_s;
    int m_items, m_disc, m_stol;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic bit f_discount(input logic [2:0] upc);
        bit u = upc[2], p = upc[1], c = upc[0];
        return (!u && !p) || (u && p && !c);
    endfunction

    function automatic bit f_stolen(input logic [2:0] upc, input bit marked);
        bit u = upc[2], p = upc[1], c = upc[0];
        return ((u && c) || (!u && !p && !c)) && !marked;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Advance the reference model by one clock edge with the given inputs
    task automatic model_step(input bit v, input logic [3:0] code, input bit e,
                              input bit a, input bit r);
        bit d, s, was_open;
        exp_t x;
        d = f_discount(code[3:1]);
        s = f_stolen(code[3:1], code[0]);
        if (r) begin
            m_in_txn = 0; m_alarm = 0; m_closing = 0;
            m_last_d = 0; m_last_s = 0;
            m_items = 0; m_disc = 0; m_stol = 0;
        end else if (m_closing) begin
            m_closing = 0;
        end else if (m_alarm) begin
            if (a) m_alarm = 0;
        end else if (v) begin
            was_open = m_in_txn;
            if (!was_open) begin
                m_items = 0; m_disc = 0; m_stol = 0;
                m_in_txn = 1;
            end
            m_items  = sat(m_items + 1, COUNT_MAX);
            m_disc   = sat(m_disc + int'(d), COUNT_MAX);
            m_stol   = sat(m_stol + int'(s), STOLEN_MAX);
            m_last_d = d;
            m_last_s = s;
            if (s) begin
                m_alarm = 1;
            end else if (was_open && e) begin
                m_closing = 1;
                m_in_txn  = 0;
            end
        end else if (m_in_txn && e) begin
            m_closing = 1;
            m_in_txn  = 0;
        end
        x.ready  = !m_alarm && !m_closing;
        x.alarm  = m_alarm;
        x.done   = m_closing;
        x.busy   = m_in_txn;
        x.last_d = m_last_d;
        x.last_s = m_last_s;
        x.items  = m_items;
        x.disc   = m_disc;
        x.stol   = m_stol;
        sb.push_back(x);
    endtask

    // Drive one cycle of inputs, queue its expectation, then cross the edge
    task automatic step(input bit v, input logic [3:0] code, input bit e,
                        input bit a, input bit r);
        bus.item_valid  = v;
        bus.item_upc    = code[3:1];
        bus.item_marked = code[0];
        bus.end_txn     = e;
        bus.alarm_ack   = a;
        reset_n         = !r;
        model_step(v, code, e, a, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation
    initial begin
        exp_t x;
        bit prev_alarm = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("item_ready",     int'(bus.item_ready),     int'(x.ready));
                check("alarm",          int'(bus.alarm),          int'(x.alarm));
                check("txn_done",       int'(bus.txn_done),       int'(x.done));
                check("busy",           int'(bus.busy),           int'(x.busy));
                check("last_discount",  int'(bus.last_discount),  int'(x.last_d));
                check("last_stolen",    int'(bus.last_stolen),    int'(x.last_s));
                check("item_count",     int'(bus.item_count),     x.items);
                check("discount_count", int'(bus.discount_count), x.disc);
                check("stolen_count",   int'(bus.stolen_count),   x.stol);
                if (bus.alarm === 1'b1 && !prev_alarm) alarm_rises++;
                prev_alarm = (bus.alarm === 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset with item_valid held high: nothing may be counted
        do_reset();
        check("reset_item_count", int'(bus.item_count), 0);
        check("reset_ready", int'(bus.item_ready), 1);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("post_reset_busy", int'(bus.busy), 0);

        // Classification sweep over all 16 {U,P,C,M} codes in one transaction
        @(negedge clk);
        base = alarm_rises;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            if (f_stolen(3'(i >> 1), i[0])) step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        check("sweep_items", int'(bus.item_count), 16);
        check("sweep_disc", int'(bus.discount_count), 6);
        check("sweep_stolen", int'(bus.stolen_count), 3);
        check("sweep_alarms", alarm_rises - base, 3);
        #1;
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back marked items, then close
        step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        check("b2b_done", int'(bus.txn_done), 1);
        check("b2b_items", int'(bus.item_count), 4);
        check("b2b_disc", int'(bus.discount_count), 3);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("b2b_done_pulse", int'(bus.txn_done), 0);
        check("b2b_idle_ready", int'(bus.item_ready), 1);

        // Alarm hold: valid held with no ack must not be accepted
        do_reset();
        step(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        check("hold_ready", int'(bus.item_ready), 0);
        check("hold_items", int'(bus.item_count), 1);
        step(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        check("hold_after_ack", int'(bus.item_count), 2);

        // Simultaneous item and end_txn
        do_reset();
        step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        check("simul_alarm", int'(bus.alarm), 1);
        check("simul_no_done", int'(bus.txn_done), 0);
        step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0);
        check("simul_done", int'(bus.txn_done), 1);
        check("simul_items", int'(bus.item_count), 3);

        // Saturation of stolen_count, then reset in the middle of ALARM
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
            step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        check("sat_stolen", int'(bus.stolen_count), 15);
        check("sat_items", int'(bus.item_count), 20);
        step(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        check("sat_alarm", int'(bus.alarm), 1);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("rst_alarm", int'(bus.alarm), 0);
        check("rst_items", int'(bus.item_count), 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 199) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
